// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. Receives a byte stream over a
// valid/ready handshake: a 16-bit big-endian word count N followed by N
// big-endian 32-bit instruction words. Each assembled word is written to
// instruction memory with a one-cycle strobe at consecutive word addresses
// starting at BASE_ADDR. The CPU is held frozen until the whole image has
// been written.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte (XOR of all count and data
//   bytes) is expected after the image. A mismatch aborts the session.
//
// Parameters:
//   ADDR_W     width of mem_addr
//   BASE_ADDR  byte address of the first word (multiple of 4)
//   MAX_WORDS  largest accepted image size in words
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         level-sampled session start (IDLE / DONE / ERROR)
//   in_valid      byte present on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   mem_we        instruction-memory write strobe, one cycle per word
//   mem_addr      byte address of the word being written
//   mem_wdata     instruction word
//   cpu_hold      high while the CPU must not fetch
//   done          image fully loaded
//   error         session aborted
//   words_loaded  words written in the current session
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}},
    parameter int unsigned        MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_TAIL   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [1:0]    rst_sync_r;
    logic          rst_core_n_s;
    logic          accept_s;
    logic          ready_next_s;
    logic [15:0]   count_r;
    logic [15:0]   count_full_s;
    logic [1:0]    byte_idx_r;
    logic [23:0]   word_r;
    logic [15:0]   words_loaded_r;
    logic          in_ready_r;
    logic          mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic          cpu_hold_r;
    logic          done_r;
    logic          error_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_r;

    // Running XOR checksum over every count and data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                               input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction
`endif

    // Reset assertion is asynchronous; release is re-timed to clk so every
    // core flop leaves reset on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_core_n_s = rst_sync_r[1];

    // in_ready_r mirrors the current state, so a transfer is simply both high.
    assign accept_s     = in_valid && in_ready_r;
    assign count_full_s = {count_r[15:8], in_data};

    // State register.
    always_ff @(posedge clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next_s = ST_HDR_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HDR_HI: begin
                if (accept_s) begin
                    state_next_s = ST_HDR_LO;
                end else begin
                    state_next_s = ST_HDR_HI;
                end
            end
            ST_HDR_LO: begin
                if (!accept_s) begin
                    state_next_s = ST_HDR_LO;
                end else if (count_full_s == 16'd0) begin
                    state_next_s = ST_TAIL;
                end else if ({16'd0, count_full_s} > 32'(MAX_WORDS)) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s && (byte_idx_r == 2'd3)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if ((words_loaded_r + 16'd1) == count_r) begin
                    state_next_s = ST_TAIL;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_TAIL: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (!accept_s) begin
                    state_next_s = ST_TAIL;
                end else if (in_data == csum_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ERROR;
                end
`else
                state_next_s = ST_DONE;
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // in_ready for the state being entered, so the registered copy lines up.
    always_comb begin
        ready_next_s = 1'b0;
        case (state_next_s)
            ST_HDR_HI, ST_HDR_LO, ST_DATA: begin
                ready_next_s = 1'b1;
            end
            ST_TAIL: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                ready_next_s = 1'b1;
`else
                ready_next_s = 1'b0;
`endif
            end
            default: begin
                ready_next_s = 1'b0;
            end
        endcase
    end

    // Session datapath: header count, byte assembly and word counter.
    always_ff @(posedge clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            count_r        <= 16'd0;
            byte_idx_r     <= 2'd0;
            word_r         <= 24'd0;
            words_loaded_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        words_loaded_r <= 16'd0;
                        byte_idx_r     <= 2'd0;
                    end
                end
                ST_HDR_HI: begin
                    if (accept_s) begin
                        count_r <= {in_data, 8'h00};
                    end
                end
                ST_HDR_LO: begin
                    if (accept_s) begin
                        count_r    <= count_full_s;
                        byte_idx_r <= 2'd0;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        word_r     <= {word_r[15:0], in_data};
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                end
                ST_WRITE: begin
                    words_loaded_r <= words_loaded_r + 16'd1;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accumulator, cleared at each session start.
    always_ff @(posedge clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            csum_r <= 8'h00;
        end else if ((state_r == ST_IDLE || state_r == ST_DONE ||
                      state_r == ST_ERROR) && start) begin
            csum_r <= 8'h00;
        end else if (accept_s && (state_r == ST_HDR_HI || state_r == ST_HDR_LO ||
                                  state_r == ST_DATA)) begin
            csum_r <= csum_update(csum_r, in_data);
        end
    end
`endif

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_ADDR;
            mem_wdata_r <= 32'd0;
            cpu_hold_r  <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            in_ready_r <= ready_next_s;
            cpu_hold_r <= (state_next_s != ST_DONE);
            done_r     <= (state_next_s == ST_DONE);
            error_r    <= (state_next_s == ST_ERROR);
            // WRITE is only ever entered from DATA, so this is a single pulse.
            mem_we_r   <= (state_next_s == ST_WRITE);
            if (state_next_s == ST_WRITE) begin
                mem_addr_r  <= BASE_ADDR + ADDR_W'({words_loaded_r, 2'b00});
                mem_wdata_r <= {word_r, in_data};
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader (MAX_WORDS = 4, BASE_ADDR = 0).
// Honours IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte to
// every well-formed stream and adding a checksum-mismatch scenario.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  cons_q[$];
    logic [7:0]  stream_q[$];
    int          ready_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes and consumed bytes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
            if (in_ready !== 1'b0) ready_viol = ready_viol + 1;
        end
        if (in_valid && in_ready === 1'b1) cons_q.push_back(in_data);
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        cons_q.delete();
        ready_viol = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        stream_q.push_back(w[31:24]);
        stream_q.push_back(w[23:16]);
        stream_q.push_back(w[15:8]);
        stream_q.push_back(w[7:0]);
    endtask

    task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream_q[i]) x = x ^ stream_q[i];
        stream_q.push_back(x);
`endif
    endtask

    task automatic do_start();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Offer stream_q byte by byte; a byte advances only when taken.
    task automatic send_stream(input bit gaps, input string tag);
        int idx;
        int budget;
        bit acc;
        idx = 0;
        budget = 0;
        while (idx < stream_q.size() && budget < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? stream_q[idx] : 8'($urandom);
            acc = in_valid && (in_ready === 1'b1);
            @(posedge clk); #2;
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        n_checks++;
        if (idx != stream_q.size()) begin
            n_errors++;
            $display("FAIL %s send: accepted %0d bytes, required %0d", tag, idx, stream_q.size());
        end
    endtask

    task automatic wait_end(input string tag);
        int b;
        b = 0;
        while (!(done === 1'b1 || error === 1'b1) && b < 200) begin
            @(posedge clk); #2;
            b++;
        end
        n_checks++;
        if (b >= 200) begin
            n_errors++;
            $display("FAIL %s timeout: done/error never asserted", tag);
        end
    endtask

    task automatic load_two_word(input bit gaps, input string tag);
        clear_mon();
        stream_q = {8'h00, 8'h02};
        push_word(32'h2008_0005);
        push_word(32'hAC08_0004);
        add_csum();
        do_start();
        send_stream(gaps, tag);
        wait_end(tag);
        n_checks++;
        if (wr_addr_q.size() !== 2) begin
            n_errors++;
            $display("FAIL %s wr_count: got %0d, required 2", tag, wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 32'h0) begin n_errors++; $display("FAIL %s addr0: got %h, required 00000000", tag, wr_addr_q[0]); end
            n_checks++;
            if (wr_data_q[0] !== 32'h2008_0005) begin n_errors++; $display("FAIL %s data0: got %h, required 20080005", tag, wr_data_q[0]); end
            n_checks++;
            if (wr_addr_q[1] !== 32'h4) begin n_errors++; $display("FAIL %s addr1: got %h, required 00000004", tag, wr_addr_q[1]); end
            n_checks++;
            if (wr_data_q[1] !== 32'hAC08_0004) begin n_errors++; $display("FAIL %s data1: got %h, required ac080004", tag, wr_data_q[1]); end
            if (!gaps) begin
                n_checks++;
                if (wr_cyc_q[1] - wr_cyc_q[0] !== 5) begin n_errors++; $display("FAIL %s spacing: got %0d cycles, required 5", tag, wr_cyc_q[1] - wr_cyc_q[0]); end
            end
        end
        n_checks++;
        if (words_loaded !== 16'd2) begin n_errors++; $display("FAIL %s words_loaded: got %0d, required 2", tag, words_loaded); end
        n_checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL %s status: done=%b cpu_hold=%b error=%b, required 1 0 0", tag, done, cpu_hold, error);
        end
        n_checks++;
        if (ready_viol !== 0) begin n_errors++; $display("FAIL %s write_ready: in_ready high in %0d WRITE cycles, required 0", tag, ready_viol); end
        n_checks++;
        if (cons_q != stream_q) begin n_errors++; $display("FAIL %s consumed: %0d bytes differ from the %0d-byte stream", tag, cons_q.size(), stream_q.size()); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset ctl: cpu_hold=%b in_ready=%b mem_we=%b, required 1 0 0", cpu_hold, in_ready, mem_we);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset mem: addr=%h wdata=%h, required 0 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
            n_errors++;
            $display("FAIL reset status: done=%b error=%b words=%0d, required 0 0 0", done, error, words_loaded);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL idle: in_ready=%b cpu_hold=%b, required 0 1", in_ready, cpu_hold);
        end
    endtask

    task automatic test_two_word();
        load_two_word(1'b0, "two_word");
    endtask

    task automatic test_back_pressure();
        load_two_word(1'b1, "back_pressure");
    endtask

    task automatic test_zero_count();
        clear_mon();
        stream_q = {8'h00, 8'h00};
        add_csum();
        do_start();
        send_stream(1'b0, "zero_count");
        wait_end("zero_count");
        n_checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd0 || wr_addr_q.size() !== 0) begin
            n_errors++;
            $display("FAIL zero_count: done=%b cpu_hold=%b words=%0d writes=%0d, required 1 0 0 0",
                     done, cpu_hold, words_loaded, wr_addr_q.size());
        end
    endtask

    task automatic test_max_words();
        clear_mon();
        stream_q = {8'h00, 8'h04};
        push_word(32'h0102_0304);
        push_word(32'h1112_1314);
        push_word(32'h2122_2324);
        push_word(32'h3132_3334);
        add_csum();
        do_start();
        send_stream(1'b0, "max_words");
        wait_end("max_words");
        n_checks++;
        if (wr_addr_q.size() !== 4) begin
            n_errors++;
            $display("FAIL max_words count: got %0d writes, required 4", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[3] !== 32'hC || wr_data_q[3] !== 32'h3132_3334) begin
                n_errors++;
                $display("FAIL max_words last: addr=%h data=%h, required 0000000c 31323334", wr_addr_q[3], wr_data_q[3]);
            end
            n_checks++;
            if (wr_addr_q[2] !== 32'h8 || wr_data_q[2] !== 32'h2122_2324) begin
                n_errors++;
                $display("FAIL max_words third: addr=%h data=%h, required 00000008 21222324", wr_addr_q[2], wr_data_q[2]);
            end
        end
        n_checks++;
        if (done !== 1'b1 || words_loaded !== 16'd4) begin
            n_errors++;
            $display("FAIL max_words status: done=%b words=%0d, required 1 4", done, words_loaded);
        end
    endtask

    task automatic test_bad_count();
        clear_mon();
        stream_q = {8'h00, 8'h05};
        do_start();
        send_stream(1'b0, "bad_count");
        wait_end("bad_count");
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_count status: error=%b cpu_hold=%b done=%b in_ready=%b, required 1 1 0 0",
                     error, cpu_hold, done, in_ready);
        end
        n_checks++;
        if (wr_addr_q.size() !== 0) begin n_errors++; $display("FAIL bad_count writes: got %0d, required 0", wr_addr_q.size()); end
        // Retry after the error.
        clear_mon();
        stream_q = {8'h00, 8'h01};
        push_word(32'hDEAD_BEEF);
        add_csum();
        do_start();
        send_stream(1'b0, "bad_count_retry");
        wait_end("bad_count_retry");
        n_checks++;
        if (wr_addr_q.size() !== 1) begin
            n_errors++;
            $display("FAIL retry count: got %0d writes, required 1", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'hDEAD_BEEF) begin
                n_errors++;
                $display("FAIL retry write: addr=%h data=%h, required 00000000 deadbeef", wr_addr_q[0], wr_data_q[0]);
            end
        end
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd1) begin
            n_errors++;
            $display("FAIL retry status: done=%b error=%b words=%0d, required 1 0 1", done, error, words_loaded);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        stream_q = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        do_start();
        send_stream(1'b0, "mid_reset");
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
            error !== 1'b0 || words_loaded !== 16'd0 || mem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL mid_reset values: hold=%b rdy=%b we=%b done=%b err=%b words=%0d addr=%h, required 1 0 0 0 0 0 0",
                     cpu_hold, in_ready, mem_we, done, error, words_loaded, mem_addr);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (wr_addr_q.size() !== 0 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset idle: writes=%0d in_ready=%b cpu_hold=%b, required 0 0 1",
                     wr_addr_q.size(), in_ready, cpu_hold);
        end
        load_two_word(1'b0, "after_reset");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        clear_mon();
        stream_q = {8'h00, 8'h02};
        push_word(32'h2008_0005);
        push_word(32'hAC08_0004);
        stream_q.push_back(8'h00);
        do_start();
        send_stream(1'b0, "csum_bad");
        wait_end("csum_bad");
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL csum_bad status: error=%b done=%b cpu_hold=%b, required 1 0 1", error, done, cpu_hold);
        end
        n_checks++;
        if (wr_addr_q.size() !== 2) begin n_errors++; $display("FAIL csum_bad writes: got %0d, required 2", wr_addr_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_word();
        test_back_pressure();
        test_zero_count();
        test_max_words();
        test_bad_count();
        test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
